// File: rtl/tinyalu_rr_arbiter.sv
// Round-robin arbiter sharing one TinyALU between N_REQ requesters.
// Latches the winner's operands, runs the ALU under a watchdog and returns a one-cycle ack.
module tinyalu_rr_arbiter #(
    parameter int N_REQ       = 4,
    parameter int TIMEOUT_CYC = 16
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic [N_REQ-1:0]     req,
    input  logic [8*N_REQ-1:0]   req_a,
    input  logic [8*N_REQ-1:0]   req_b,
    input  logic [3*N_REQ-1:0]   req_op,
    output logic [N_REQ-1:0]     ack,
    output logic [15:0]          rsp_result,
    output logic                 rsp_err,
    output logic [7:0]           alu_a,
    output logic [7:0]           alu_b,
    output logic [2:0]           alu_op,
    output logic                 alu_start,
    input  logic                 alu_done,
    input  logic [15:0]          alu_result
);

    localparam int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam int WD_W  = $clog2(TIMEOUT_CYC + 1);

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        ABORT,
        RESP
    } state_t;

    state_t            state;
    state_t            state_nxt;
    logic [IDX_W-1:0]  ptr;
    logic [WD_W-1:0]   wd_cnt;

    logic [7:0]        a_q;
    logic [7:0]        b_q;
    logic [2:0]        op_q;
    logic [15:0]       res_q;
    logic              err_q;

    logic              win_found;
    logic [IDX_W-1:0]  win_idx;
    logic [IDX_W-1:0]  cand;
    logic [7:0]        win_a;
    logic [7:0]        win_b;
    logic [2:0]        win_op;

    logic              ld_req;
    logic              ld_res;
    logic [15:0]       res_nxt;
    logic              err_nxt;

    // Circular search starting just after the last winner
    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        cand      = '0;
        for (int k = 1; k <= N_REQ; k++) begin
            cand = IDX_W'((int'(ptr) + k) % N_REQ);
            if (!win_found && req[cand]) begin
                win_found = 1'b1;
                win_idx   = cand;
            end
        end
    end

    assign win_a  = req_a[int'(win_idx)*8 +: 8];
    assign win_b  = req_b[int'(win_idx)*8 +: 8];
    assign win_op = req_op[int'(win_idx)*3 +: 3];

    always_comb begin
        state_nxt  = state;
        ld_req     = 1'b0;
        ld_res     = 1'b0;
        res_nxt    = '0;
        err_nxt    = 1'b0;
        ack        = '0;
        rsp_result = '0;
        rsp_err    = 1'b0;
        alu_a      = '0;
        alu_b      = '0;
        alu_op     = '0;
        alu_start  = 1'b0;
        case (state)
            IDLE: begin
                if (win_found) begin
                    ld_req = 1'b1;
                    if (win_op == 3'b000) begin
                        ld_res    = 1'b1;
                        state_nxt = RESP;
                    end else if (win_op >= 3'b101) begin
                        ld_res    = 1'b1;
                        err_nxt   = 1'b1;
                        state_nxt = RESP;
                    end else begin
                        state_nxt = ISSUE;
                    end
                end
            end
            ISSUE: begin
                alu_start = 1'b1;
                alu_a     = a_q;
                alu_b     = b_q;
                alu_op    = op_q;
                // done takes priority over an expiring watchdog
                if (alu_done) begin
                    ld_res    = 1'b1;
                    res_nxt   = alu_result;
                    state_nxt = RESP;
                end else if (wd_cnt == WD_W'(TIMEOUT_CYC - 1)) begin
                    state_nxt = ABORT;
                end
            end
            ABORT: begin
                ld_res    = 1'b1;
                err_nxt   = 1'b1;
                state_nxt = RESP;
            end
            RESP: begin
                ack[ptr]   = 1'b1;
                rsp_result = res_q;
                rsp_err    = err_q;
                state_nxt  = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state  <= IDLE;
            ptr    <= IDX_W'(N_REQ - 1);
            wd_cnt <= '0;
        end else begin
            state  <= state_nxt;
            if (ld_req) begin
                ptr <= win_idx;
            end
            wd_cnt <= (state == ISSUE) ? wd_cnt + WD_W'(1) : '0;
        end
    end

    // Operand and result holding registers; only ever observed through state-gated outputs
    always_ff @(posedge clk) begin
        if (ld_req) begin
            a_q  <= win_a;
            b_q  <= win_b;
            op_q <= win_op;
        end
        if (ld_res) begin
            res_q <= res_nxt;
            err_q <= err_nxt;
        end
    end

endmodule
